// File: rtl/digit_window_scroller.sv
// digit_window_scroller
//   Holds a snapshot of NUM_DIGITS digits and shows a WIN-digit window of it
//   on a seven-segment driver. The window is moved with two raw push buttons,
//   which are synchronised, debounced and edge-detected on chip. An optional
//   timed auto-scroll steps the window right; WRAP selects saturating or
//   circular indexing.
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   btn_left, btn_right : raw asynchronous buttons (left -> toward digit 0)
//   auto_en             : enable auto-scroll to the right
//   load, digits_in     : capture strobe and digit vector (digit 0 in LSBs)
//   win_out             : WIN displayed digits (slot 0 in LSBs)
//   offset              : buffer index shown in slot 0
//   at_left, at_right   : offset == 0 / offset == MAX_OFF
//   moved               : one-cycle pulse after offset changed

// Per-button conditioner: 2-flop synchroniser, debounce counter, rise detect.
module dws_btn_cond #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          s1_q, s1_d, s2_q, s2_d;
  logic          deb_q, deb_d, deb_dly_q, deb_dly_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    cnt_d     = '0;
    // Count only while the synced level disagrees; the edge that would make
    // the count reach DEB_CYCLES flips the level instead.
    if (s2_q != deb_q) begin
      if (cnt_q == DW'(DEB_CYCLES - 1)) deb_d = ~deb_q;
      else                              cnt_d = cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  assign press = deb_q & ~deb_dly_q;
endmodule

module digit_window_scroller #(
  parameter int DIGIT_W     = 4,
  parameter int NUM_DIGITS  = 5,
  parameter int WIN         = 3,
  parameter int WRAP        = 0,
  parameter int DEB_CYCLES  = 4,
  parameter int AUTO_PERIOD = 50000000,
  localparam int OW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          btn_left,
  input  logic                          btn_right,
  input  logic                          auto_en,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  output logic [WIN*DIGIT_W-1:0]        win_out,
  output logic [OW-1:0]                 offset,
  output logic                          at_left,
  output logic                          at_right,
  output logic                          moved
);
  localparam int MAX_OFF = (WRAP != 0) ? NUM_DIGITS - 1 : NUM_DIGITS - WIN;
  localparam int TW      = $clog2(AUTO_PERIOD);
  localparam logic [OW-1:0] MAX_L = OW'(MAX_OFF);

  // index 0 = left button, 1 = right button
  logic [1:0] btn_raw, btn_press;
  assign btn_raw = {btn_right, btn_left};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    dws_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_cond (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[b]),
      .press (btn_press[b])
    );
  end

  logic                          press_l, press_r, tick;
  logic [TW-1:0]                 tmr_q, tmr_d;
  logic [OW-1:0]                 off_q, off_d;
  logic                          moved_q, moved_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] buf_q, buf_d;

  assign press_l = btn_press[0];
  assign press_r = btn_press[1];
  assign tick    = auto_en && (tmr_q == TW'(AUTO_PERIOD - 1));

  always_comb begin
    tmr_d = '0;
    if (auto_en && !(press_l || press_r || tick)) tmr_d = tmr_q + TW'(1);

    off_d = off_q;
    if (press_l && !press_r) begin
      if (off_q != '0)    off_d = off_q - OW'(1);
      else if (WRAP != 0) off_d = MAX_L;
    end else if (press_r && !press_l) begin
      if (off_q != MAX_L) off_d = off_q + OW'(1);
      else if (WRAP != 0) off_d = '0;
    end else if (!press_l && !press_r && tick) begin
      // Auto-scroll always restarts the marquee at the right end.
      if (off_q != MAX_L) off_d = off_q + OW'(1);
      else                off_d = '0;
    end

    moved_d = (off_d != off_q);
    buf_d   = load ? digits_in : buf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q   <= '0;
      off_q   <= '0;
      moved_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      tmr_q   <= tmr_d;
      off_q   <= off_d;
      moved_q <= moved_d;
      buf_q   <= buf_d;
    end
  end

  // offset+j never exceeds 2*NUM_DIGITS-2, so one subtraction is a full mod.
  always_comb begin
    win_out = '0;
    for (int j = 0; j < WIN; j++) begin
      int idx;
      idx = int'(off_q) + j;
      if (WRAP != 0 && idx >= NUM_DIGITS) idx = idx - NUM_DIGITS;
      win_out[j*DIGIT_W +: DIGIT_W] = buf_q[idx*DIGIT_W +: DIGIT_W];
    end
  end

  assign offset   = off_q;
  assign at_left  = (off_q == '0);
  assign at_right = (off_q == MAX_L);
  assign moved    = moved_q;
endmodule

// File: tb/tb_digit_window_scroller.sv
// Directed bench: three DUT instances share all inputs.
//   u_def  : default parameters (WRAP=0)
//   u_wrap : WRAP=1
//   u_auto : AUTO_PERIOD=8, WRAP=0
module tb_digit_window_scroller;
  logic        clk = 1'b0;
  logic        reset, btn_left, btn_right, auto_en, load;
  logic [19:0] digits_in;
  logic [11:0] win_a, win_b, win_c;
  logic [2:0]  off_a, off_b, off_c;
  logic        atl_a, atr_a, mv_a, atl_b, atr_b, mv_b, atl_c, atr_c, mv_c;

  int checks = 0;
  int errors = 0;
  int mvc_a = 0, mvc_b = 0, mvc_c = 0;

  localparam logic [19:0] DIGS = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

  always #5 clk = ~clk;

  digit_window_scroller u_def (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .auto_en(auto_en), .load(load), .digits_in(digits_in), .win_out(win_a),
    .offset(off_a), .at_left(atl_a), .at_right(atr_a), .moved(mv_a));

  digit_window_scroller #(.WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .auto_en(auto_en), .load(load), .digits_in(digits_in), .win_out(win_b),
    .offset(off_b), .at_left(atl_b), .at_right(atr_b), .moved(mv_b));

  digit_window_scroller #(.AUTO_PERIOD(8)) u_auto (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .auto_en(auto_en), .load(load), .digits_in(digits_in), .win_out(win_c),
    .offset(off_c), .at_left(atl_c), .at_right(atr_c), .moved(mv_c));

  // moved pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (mv_a === 1'b1) mvc_a++;
    if (mv_b === 1'b1) mvc_b++;
    if (mv_c === 1'b1) mvc_c++;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    reset = 1'b1; btn_left = 1'b0; btn_right = 1'b0; auto_en = 1'b0; load = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic do_load;
    digits_in = DIGS; load = 1'b1; cyc(1); load = 1'b0;
  endtask

  task automatic press(input logic l, input logic r);
    btn_left = l; btn_right = r; cyc(8);
    btn_left = 1'b0; btn_right = 1'b0; cyc(12);
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (win_a !== 12'h000) begin errors++; $display("FAIL reset_win: got %h expected %h", win_a, 12'h000); end
    checks++; if (off_a !== 3'd0) begin errors++; $display("FAIL reset_off: got %0d expected 0", off_a); end
    checks++; if (atl_a !== 1'b1) begin errors++; $display("FAIL reset_at_left: got %b expected 1", atl_a); end
    checks++; if (atr_a !== 1'b0) begin errors++; $display("FAIL reset_at_right: got %b expected 0", atr_a); end
    checks++; if (mv_a !== 1'b0) begin errors++; $display("FAIL reset_moved: got %b expected 0", mv_a); end
    checks++; if (atr_b !== 1'b0) begin errors++; $display("FAIL reset_wrap_at_right: got %b expected 0", atr_b); end
  endtask

  task automatic test_basic;
    int m;
    do_reset; do_load;
    checks++; if (win_a !== 12'h321) begin errors++; $display("FAIL load_win: got %h expected %h", win_a, 12'h321); end
    m = mvc_a;
    btn_right = 1'b1;
    cyc(6);
    checks++; if (off_a !== 3'd0) begin errors++; $display("FAIL latency_edge6: got %0d expected 0", off_a); end
    cyc(1);
    checks++; if (off_a !== 3'd1) begin errors++; $display("FAIL latency_edge7: got %0d expected 1", off_a); end
    checks++; if (mv_a !== 1'b1) begin errors++; $display("FAIL moved_edge7: got %b expected 1", mv_a); end
    checks++; if (win_a !== 12'h432) begin errors++; $display("FAIL step_win: got %h expected %h", win_a, 12'h432); end
    cyc(1);
    checks++; if (mv_a !== 1'b0) begin errors++; $display("FAIL moved_edge8: got %b expected 0", mv_a); end
    btn_right = 1'b0; cyc(12);
    checks++; if (mvc_a - m !== 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", mvc_a - m); end
  endtask

  task automatic test_saturate;
    int m;
    int exp_mv[4] = '{1, 1, 0, 0};
    do_reset; do_load;
    for (int k = 0; k < 4; k++) begin
      m = mvc_a;
      press(1'b0, 1'b1);
      checks++; if (mvc_a - m !== exp_mv[k]) begin errors++; $display("FAIL sat_moved_%0d: got %0d expected %0d", k, mvc_a - m, exp_mv[k]); end
    end
    checks++; if (off_a !== 3'd2) begin errors++; $display("FAIL sat_off: got %0d expected 2", off_a); end
    checks++; if (win_a !== 12'h543) begin errors++; $display("FAIL sat_win: got %h expected %h", win_a, 12'h543); end
    checks++; if (atr_a !== 1'b1 || atl_a !== 1'b0) begin errors++; $display("FAIL sat_flags: got %b%b expected 10", atr_a, atl_a); end
    press(1'b1, 1'b0); press(1'b1, 1'b0);
    checks++; if (off_a !== 3'd0) begin errors++; $display("FAIL left_back: got %0d expected 0", off_a); end
    m = mvc_a;
    press(1'b1, 1'b0);
    checks++; if (off_a !== 3'd0 || mvc_a - m !== 0) begin errors++; $display("FAIL left_sat: got off %0d pulses %0d expected 0 0", off_a, mvc_a - m); end
  endtask

  task automatic test_bounce;
    int m;
    do_reset; do_load;
    m = mvc_a;
    repeat (6) begin btn_right = 1'b1; cyc(3); btn_right = 1'b0; cyc(2); end
    cyc(10);
    checks++; if (off_a !== 3'd0 || mvc_a - m !== 0) begin errors++; $display("FAIL bounce_reject: got off %0d pulses %0d expected 0 0", off_a, mvc_a - m); end
    press(1'b0, 1'b1);
    checks++; if (off_a !== 3'd1) begin errors++; $display("FAIL bounce_hold: got %0d expected 1", off_a); end
    press(1'b0, 1'b1);
    checks++; if (off_a !== 3'd2 || mvc_a - m !== 2) begin errors++; $display("FAIL bounce_repress: got off %0d pulses %0d expected 2 2", off_a, mvc_a - m); end
  endtask

  task automatic test_wrap;
    do_reset; do_load;
    repeat (4) press(1'b0, 1'b1);
    checks++; if (off_b !== 3'd4) begin errors++; $display("FAIL wrap_off4: got %0d expected 4", off_b); end
    checks++; if (win_b !== 12'h215) begin errors++; $display("FAIL wrap_win: got %h expected %h", win_b, 12'h215); end
    checks++; if (atr_b !== 1'b1) begin errors++; $display("FAIL wrap_at_right: got %b expected 1", atr_b); end
    press(1'b0, 1'b1);
    checks++; if (off_b !== 3'd0 || atl_b !== 1'b1) begin errors++; $display("FAIL wrap_right: got off %0d at_left %b expected 0 1", off_b, atl_b); end
    press(1'b1, 1'b0);
    checks++; if (off_b !== 3'd4) begin errors++; $display("FAIL wrap_left: got %0d expected 4", off_b); end
  endtask

  task automatic test_auto;
    int       ce[6]       = '{7, 8, 15, 16, 23, 24};
    int       co[6]       = '{0, 1, 1, 2, 2, 0};
    int       p;
    do_reset; do_load;
    auto_en = 1'b1;
    p = 0;
    for (int e = 1; e <= 24; e++) begin
      cyc(1);
      if (p < 6 && e == ce[p]) begin
        checks++; if (off_c !== co[p][2:0]) begin errors++; $display("FAIL auto_edge%0d: got %0d expected %0d", e, off_c, co[p]); end
        p++;
      end
    end
    checks++; if (mv_c !== 1'b1) begin errors++; $display("FAIL auto_restart_moved: got %b expected 1", mv_c); end
    auto_en = 1'b0; cyc(2);
  endtask

  task automatic test_auto_restart;
    do_reset; do_load;
    auto_en = 1'b1; btn_right = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      cyc(1);
      if (e == 7 || e == 8 || e == 14) begin
        checks++; if (off_c !== 3'd1) begin errors++; $display("FAIL timer_restart_edge%0d: got %0d expected 1", e, off_c); end
      end
      if (e == 15) begin
        checks++; if (off_c !== 3'd2) begin errors++; $display("FAIL timer_restart_edge15: got %0d expected 2", off_c); end
      end
    end
    auto_en = 1'b0; btn_right = 1'b0; cyc(12);
  endtask

  task automatic test_both;
    int m;
    do_reset; do_load;
    press(1'b0, 1'b1);
    m = mvc_a;
    press(1'b1, 1'b1);
    checks++; if (off_a !== 3'd1 || mvc_a - m !== 0) begin errors++; $display("FAIL both_buttons: got off %0d pulses %0d expected 1 0", off_a, mvc_a - m); end
  endtask

  task automatic test_reset_mid;
    do_reset; do_load;
    press(1'b0, 1'b1);
    btn_right = 1'b1;
    cyc(4);
    reset = 1'b1; cyc(1);
    checks++; if (off_a !== 3'd0 || win_a !== 12'h000) begin errors++; $display("FAIL mid_reset_state: got off %0d win %h expected 0 000", off_a, win_a); end
    reset = 1'b0;
    cyc(6);
    checks++; if (off_a !== 3'd0) begin errors++; $display("FAIL mid_reset_edge6: got %0d expected 0", off_a); end
    cyc(1);
    checks++; if (off_a !== 3'd1 || mv_a !== 1'b1) begin errors++; $display("FAIL mid_reset_edge7: got off %0d moved %b expected 1 1", off_a, mv_a); end
    btn_right = 1'b0; cyc(12);
  endtask

  initial begin
    reset = 1'b1; btn_left = 1'b0; btn_right = 1'b0; auto_en = 1'b0; load = 1'b0;
    digits_in = '0;
    test_reset;
    test_basic;
    test_saturate;
    test_bounce;
    test_wrap;
    test_auto;
    test_auto_restart;
    test_both;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
